// File: rtl/sprite_pixel_server.sv
// rtl/sprite_pixel_server.sv - runtime-loadable sprite RAM answering overlay pixel reads one clock later
// Optional horizontal mirroring: define SPRITE_MIRROR_EN to add the mirror_x port.
module sprite_pixel_server #(
  parameter int          RECT_WIDTH  = 48,
  parameter int          RECT_HEIGHT = 64,
  parameter logic [11:0] FILL_RGB    = 12'h000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [13:0] pixel_addr,
  output logic [11:0] rgb_pixel,
  input  logic        load_start,
  input  logic        wr_valid,
  input  logic [11:0] wr_data,
  output logic        wr_ready,
  output logic        load_busy,
  output logic        load_done,
  output logic        sprite_valid
`ifdef SPRITE_MIRROR_EN
  ,
  input  logic        mirror_x
`endif
);

  localparam int LOG_S    = $clog2(RECT_WIDTH);
  localparam int ROW_BITS = 14 - LOG_S;
  localparam int DEPTH    = RECT_HEIGHT * (1 << LOG_S);
  localparam int AW       = $clog2(DEPTH);

  typedef enum logic [1:0] {IDLE, LOAD, READY} state_t;

  state_t              state_q, state_d;
  logic [LOG_S-1:0]    col_q;
  logic [ROW_BITS-1:0] row_q;
  logic                load_done_q;
  logic                sprite_valid_q;
  logic                xfer;
  logic                last_xfer;
  logic [11:0]         mem [DEPTH];

  logic [LOG_S-1:0]    rd_col;
  logic [ROW_BITS-1:0] rd_row;
  logic [LOG_S-1:0]    eff_col;
  logic                col_ok;
  logic                row_ok;
  logic [AW-1:0]       rd_addr;
  logic [AW-1:0]       wr_addr;

  // A restart request wins over a same-cycle beat, so that beat is never written.
  assign xfer      = (state_q == LOAD) && wr_valid && !load_start;
  assign last_xfer = xfer && (col_q == LOG_S'(RECT_WIDTH - 1))
                          && (row_q == ROW_BITS'(RECT_HEIGHT - 1));

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    wr_ready  = 1'b0;
    load_busy = 1'b0;
    case (state_q)
      IDLE, READY: begin
        if (load_start) state_d = LOAD;
      end
      LOAD: begin
        wr_ready  = 1'b1;
        load_busy = 1'b1;
        if (load_start)     state_d = LOAD;
        else if (last_xfer) state_d = READY;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      col_q          <= '0;
      row_q          <= '0;
      load_done_q    <= 1'b0;
      sprite_valid_q <= 1'b0;
    end else begin
      load_done_q <= last_xfer;
      if (load_start) begin
        col_q          <= '0;
        row_q          <= '0;
        sprite_valid_q <= 1'b0;
      end else if (xfer) begin
        if (col_q == LOG_S'(RECT_WIDTH - 1)) begin
          col_q <= '0;
          row_q <= row_q + ROW_BITS'(1);
        end else begin
          col_q <= col_q + LOG_S'(1);
        end
        if (last_xfer) sprite_valid_q <= 1'b1;
      end
    end
  end

  assign wr_addr = AW'({row_q, col_q});

  always_ff @(posedge clk) begin
    if (xfer) mem[wr_addr] <= wr_data;
  end

  assign rd_col = pixel_addr[LOG_S-1:0];
  assign rd_row = pixel_addr[13:LOG_S];
  assign col_ok = int'(rd_col) < RECT_WIDTH;
  assign row_ok = int'(rd_row) < RECT_HEIGHT;

`ifdef SPRITE_MIRROR_EN
  assign eff_col = (mirror_x && col_ok) ? (LOG_S'(RECT_WIDTH - 1) - rd_col) : rd_col;
`else
  assign eff_col = rd_col;
`endif

  // Out-of-range addresses may alias inside the RAM; the fill mux hides that.
  assign rd_addr = AW'({rd_row, eff_col});

  always_ff @(posedge clk) begin
    if (rst)                                  rgb_pixel <= FILL_RGB;
    else if (!sprite_valid_q || !col_ok || !row_ok) rgb_pixel <= FILL_RGB;
    else                                      rgb_pixel <= mem[rd_addr];
  end

  assign load_done    = load_done_q;
  assign sprite_valid = sprite_valid_q;

endmodule
